// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue: captures golden nonces from the hasher cores, queues them in a
// small FIFO through a round-robin arbiter, and hands them one word at a time to
// serial_transmit. A load_flag toggle flushes queued and pending nonces.
// Optional build macro GOLDEN_NONCE_DEDUP_EN: drop a selected nonce that equals the
// most recently written one.
module golden_nonce_queue #(
  parameter int unsigned NUM_HASHERS = 6,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DEPTH_LOG2  = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_HASHERS-1:0]    nonce_valid,
  input  logic [32*NUM_HASHERS-1:0] nonce_in,
  input  logic                      load_flag,
  input  logic                      tx_busy,
  output logic                      tx_send,
  output logic [31:0]               tx_word,
  output logic [DEPTH_LOG2:0]       fifo_count,
  output logic                      overflow
);

  localparam int unsigned PtrW = (NUM_HASHERS > 1) ? $clog2(NUM_HASHERS) : 1;
  localparam logic [PtrW:0] NumH = (PtrW+1)'(NUM_HASHERS);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_HASHERS - 1);
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitIdle} state_e;

  logic                   r_load_flag_d;
  logic                   w_flush;
  logic [NUM_HASHERS-1:0] r_pending;
  logic [31:0]            r_hold [NUM_HASHERS];
  logic                   r_overflow;
  logic [PtrW-1:0]        r_arb_ptr;
  logic [PtrW-1:0]        w_sel;
  logic [PtrW:0]          w_sum;
  logic                   w_sel_found;
  logic                   w_take;
  logic                   w_push;
  logic [NUM_HASHERS-1:0] w_drain;
  logic [31:0]            w_sel_word;
  logic [31:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  r_wptr;
  logic [DEPTH_LOG2-1:0]  r_rptr;
  logic [DEPTH_LOG2:0]    r_count;
  logic                   w_pop;
  state_e                 r_state;
  state_e                 w_state_d;
  logic [1:0]             r_guard;
  logic [1:0]             w_guard_d;
  logic                   r_tx_send;
  logic [31:0]            r_tx_word;

  assign w_flush    = load_flag ^ r_load_flag_d;
  assign w_sel_word = r_hold[w_sel];
  // Arbiter judges fullness on the pre-pop count; a flush cycle writes nothing.
  assign w_take     = w_sel_found && (r_count < DepthCnt) && !w_flush;
  assign w_pop      = (r_state == StIdle) && (r_count != '0) && !tx_busy;

  assign tx_send    = r_tx_send;
  assign tx_word    = r_tx_word;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // Delayed copy of load_flag for toggle detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_load_flag_d <= 1'b0;
    else          r_load_flag_d <= load_flag;
  end

  // Round-robin search: first pending index at or after the pointer, wrapping.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel       = '0;
    w_sum       = '0;
    for (int unsigned k = 0; k < NUM_HASHERS; k++) begin
      w_sum = {1'b0, r_arb_ptr} + (PtrW+1)'(k);
      if (w_sum >= NumH) w_sum = w_sum - NumH;
      if (!w_sel_found && r_pending[w_sum[PtrW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel       = w_sum[PtrW-1:0];
      end
    end
  end

  // One-hot of the hasher whose pending nonce is consumed this cycle.
  always_comb begin
    w_drain = '0;
    if (w_take) w_drain[w_sel] = 1'b1;
  end

`ifdef GOLDEN_NONCE_DEDUP_EN
  logic [31:0] r_last;
  logic        r_last_vld;

  assign w_push = w_take && !(r_last_vld && (r_last == w_sel_word));

  // Remember the last nonce written so a repeat can be dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else if (w_flush) begin
      r_last_vld <= 1'b0;
    end else if (w_push) begin
      r_last     <= w_sel_word;
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_push = w_take;
`endif

  // Capture stage: hold register and pending bit per hasher, sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < NUM_HASHERS; i++) r_hold[i] <= '0;
    end else if (w_flush) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_HASHERS; i++) begin
        if (nonce_valid[i]) begin
          r_hold[i]    <= nonce_in[32*i +: 32];
          r_pending[i] <= 1'b1;
          // Overwriting a nonce that is not leaving this cycle loses it.
          if (r_pending[i] && !w_drain[i]) r_overflow <= 1'b1;
        end else if (w_drain[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Arbiter pointer moves past the served hasher, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_arb_ptr <= '0;
    else if (w_take) r_arb_ptr <= (w_sel == LastIdx) ? '0 : w_sel + PtrW'(1);
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_sel_word;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      if (w_push && !w_pop)      r_count <= r_count + (DEPTH_LOG2+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (DEPTH_LOG2+1)'(1);
    end
  end

  // Output FSM next state; WAIT_BUSY gives up after four quiet cycles.
  always_comb begin
    w_state_d = r_state;
    w_guard_d = r_guard;
    unique case (r_state)
      StIdle: begin
        if (w_pop) begin
          w_state_d = StWaitBusy;
          w_guard_d = '0;
        end
      end
      StWaitBusy: begin
        if (tx_busy)               w_state_d = StWaitIdle;
        else if (r_guard == 2'd3)  w_state_d = StIdle;
        else                       w_guard_d = r_guard + 2'd1;
      end
      StWaitIdle: begin
        if (!tx_busy) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output FSM state, send strobe and held word; flush does not touch these.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_guard   <= '0;
      r_tx_send <= 1'b0;
      r_tx_word <= '0;
    end else begin
      r_state   <= w_state_d;
      r_guard   <= w_guard_d;
      r_tx_send <= w_pop;
      if (w_pop) r_tx_word <= r_mem[r_rptr];
    end
  end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Bench for golden_nonce_queue: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_golden_nonce_queue;

  localparam int unsigned NH    = 6;
  localparam int unsigned DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NH-1:0]   nonce_valid = '0;
  logic [32*NH-1:0] nonce_in = '0;
  logic            load_flag = 1'b0;
  logic            tx_busy = 1'b0;
  logic            tx_send;
  logic [31:0]     tx_word;
  logic [3:0]      fifo_count;
  logic            overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic auto_busy = 1'b0;
  int   busy_left = 0;

  // Reference model state
  logic [NH-1:0] m_pend;
  logic [31:0]   m_hold [NH];
  int            m_ptr;
  logic [31:0]   m_fifo [$];
  logic          m_ovf;
  int            m_phase;   // 0 ready, 1 awaiting busy, 2 awaiting idle
  int            m_guard;
  logic          m_send;
  logic [31:0]   m_word;
  logic          m_lfd;
  logic [31:0]   m_last;
  logic          m_last_vld;
  logic [31:0]   m_sent [$];
  logic [31:0]   d_sent [$];
  logic [31:0]   exp_q [$];

  golden_nonce_queue #(
    .NUM_HASHERS(NH),
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .nonce_valid(nonce_valid),
    .nonce_in   (nonce_in),
    .load_flag  (load_flag),
    .tx_busy    (tx_busy),
    .tx_send    (tx_send),
    .tx_word    (tx_word),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string name, input logic [31:0] got [$],
                           input logic [31:0] exp [$]);
    check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
  endtask

  task automatic m_reset();
    m_pend = '0;
    for (int i = 0; i < NH; i++) m_hold[i] = '0;
    m_ptr = 0;
    m_fifo.delete();
    m_ovf = 1'b0;
    m_phase = 0;
    m_guard = 0;
    m_send = 1'b0;
    m_word = '0;
    m_lfd = 1'b0;
    m_last = '0;
    m_last_vld = 1'b0;
  endtask

  task automatic m_step();
    logic flush;
    logic pop;
    int   sel;
    flush = load_flag ^ m_lfd;
    pop = (m_phase == 0) && (m_fifo.size() != 0) && !tx_busy;
    sel = -1;
    if (m_fifo.size() < DEPTH)
      for (int k = 0; k < NH; k++)
        if (sel < 0 && m_pend[(m_ptr + k) % NH]) sel = (m_ptr + k) % NH;
    // transmit handshake
    m_send = 1'b0;
    if (m_phase == 0) begin
      if (pop) begin
        m_send = 1'b1;
        m_word = m_fifo[0];
        m_sent.push_back(m_word);
        m_phase = 1;
        m_guard = 0;
      end
    end else if (m_phase == 1) begin
      if (tx_busy) m_phase = 2;
      else begin
        m_guard++;
        if (m_guard == 4) m_phase = 0;
      end
    end else if (!tx_busy) begin
      m_phase = 0;
    end
    // queue side
    if (flush) begin
      m_fifo.delete();
      m_pend = '0;
`ifdef GOLDEN_NONCE_DEDUP_EN
      m_last_vld = 1'b0;
`endif
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (sel >= 0) begin
`ifdef GOLDEN_NONCE_DEDUP_EN
        if (!(m_last_vld && m_last == m_hold[sel])) begin
          m_fifo.push_back(m_hold[sel]);
          m_last = m_hold[sel];
          m_last_vld = 1'b1;
        end
`else
        m_fifo.push_back(m_hold[sel]);
`endif
        m_pend[sel] = 1'b0;
        m_ptr = (sel + 1) % NH;
      end
      for (int i = 0; i < NH; i++) begin
        if (nonce_valid[i]) begin
          if (m_pend[i]) m_ovf = 1'b1;
          m_hold[i] = nonce_in[32*i +: 32];
          m_pend[i] = 1'b1;
        end
      end
    end
    m_lfd = load_flag;
  endtask

  // Model advances on every clock edge and resets asynchronously.
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else          m_step();
    end
  end

  // Per-cycle compare against the model, and a log of words the DUT sent.
  initial begin
    forever begin
      @(negedge clk);
      check("tx_send", 32'(tx_send), 32'(m_send));
      check("tx_word", tx_word, m_word);
      check("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (reset_n && tx_send) d_sent.push_back(tx_word);
    end
  end

  // Optional serial_transmit stand-in: busy for 40 cycles after each send.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (auto_busy) begin
        if (tx_send) busy_left = 40;
        if (busy_left > 0) begin
          tx_busy = 1'b1;
          busy_left--;
        end else begin
          tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    auto_busy = 1'b0;
    busy_left = 0;
    tx_busy = 1'b0;
    nonce_valid = '0;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    m_sent.delete();
    d_sent.delete();
  endtask

  initial begin
    // Reset values
    step(2);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_word", tx_word, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    step(2);

    // Single nonce, latency E+1 write, E+2 send
    nonce_in = '0;
    nonce_in[64 +: 32] = 32'hDEADBEEF;
    nonce_valid = 6'b000100;
    step();
    nonce_valid = '0;
    step();
    check("t1_count_after_write", 32'(fifo_count), 32'd1);
    check("t1_send_early", 32'(tx_send), 32'd0);
    step();
    check("t1_send", 32'(tx_send), 32'd1);
    check("t1_word", tx_word, 32'hDEADBEEF);
    check("t1_count_after_pop", 32'(fifo_count), 32'd0);
    step();
    check("t1_send_one_cycle", 32'(tx_send), 32'd0);
    check("t1_word_held", tx_word, 32'hDEADBEEF);
    step(10);
    exp_q.delete();
    exp_q.push_back(32'hDEADBEEF);
    check_seq("t1_model_sent", m_sent, exp_q);
    check_seq("t1_dut_sent", d_sent, exp_q);

    // All hashers at once, round-robin order from pointer 0
    do_reset();
    auto_busy = 1'b1;
    for (int i = 0; i < NH; i++) nonce_in[32*i +: 32] = 32'h100 + 32'(i);
    nonce_valid = '1;
    step();
    nonce_valid = '0;
    step(320);
    exp_q.delete();
    for (int i = 0; i < NH; i++) exp_q.push_back(32'h100 + 32'(i));
    check_seq("t2_model_sent", m_sent, exp_q);
    check_seq("t2_dut_sent", d_sent, exp_q);
    check("t2_overflow", 32'(overflow), 32'd0);
    check("t2_count", 32'(fifo_count), 32'd0);

    // FIFO full, nonce 9 overwritten by 10
    do_reset();
    tx_busy = 1'b1;
    for (int v = 1; v <= 10; v++) begin
      nonce_in[0 +: 32] = 32'(v);
      nonce_valid = 6'b000001;
      step();
      nonce_valid = '0;
      step();
    end
    step(2);
    check("t3_count_full", 32'(fifo_count), 32'd8);
    check("t3_overflow", 32'(overflow), 32'd1);
    busy_left = 0;
    auto_busy = 1'b1;
    step(450);
    exp_q.delete();
    for (int v = 1; v <= 8; v++) exp_q.push_back(32'(v));
    exp_q.push_back(32'd10);
    check_seq("t3_model_sent", m_sent, exp_q);
    check_seq("t3_dut_sent", d_sent, exp_q);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    check("t3_count_drained", 32'(fifo_count), 32'd0);

    // Flush discards queue, pending bits and same-cycle captures
    do_reset();
    tx_busy = 1'b1;
    nonce_in[0 +: 32]  = 32'hA1;
    nonce_in[32 +: 32] = 32'hA2;
    nonce_in[64 +: 32] = 32'hA3;
    nonce_valid = 6'b000111;
    step();
    nonce_valid = '0;
    step(4);
    check("t4_count_queued", 32'(fifo_count), 32'd3);
    load_flag = ~load_flag;
    nonce_in[96 +: 32] = 32'hA4;
    nonce_valid = 6'b001000;
    step();
    nonce_valid = '0;
    check("t4_count_flushed", 32'(fifo_count), 32'd0);
    step();
    check("t4_count_stays", 32'(fifo_count), 32'd0);
    tx_busy = 1'b0;
    step(20);
    check("t4_model_no_send", 32'(m_sent.size()), 32'd0);
    check("t4_dut_no_send", 32'(d_sent.size()), 32'd0);

    // Reset in WAIT_IDLE with four words queued
    do_reset();
    auto_busy = 1'b1;
    for (int i = 0; i < 5; i++) nonce_in[32*i +: 32] = 32'h500 + 32'(i);
    nonce_valid = 6'b011111;
    step();
    nonce_valid = '0;
    step(10);
    check("t5_count_before", 32'(fifo_count), 32'd4);
    check("t5_sent_before", 32'(d_sent.size()), 32'd1);
    if (d_sent.size() > 0) check("t5_first_word", d_sent[0], 32'h500);
    reset_n = 1'b0;
    #1;
    check("t5_send_in_reset", 32'(tx_send), 32'd0);
    check("t5_count_in_reset", 32'(fifo_count), 32'd0);
    d_sent.delete();
    m_sent.delete();
    step(2);
    reset_n = 1'b1;
    step(80);
    check("t5_model_no_send", 32'(m_sent.size()), 32'd0);
    check("t5_dut_no_send", 32'(d_sent.size()), 32'd0);

    // Same nonce from two hashers
    do_reset();
    auto_busy = 1'b1;
    nonce_in[32 +: 32] = 32'h0000ABCD;
    nonce_valid = 6'b000010;
    step();
    nonce_valid = '0;
    step(3);
    nonce_in[96 +: 32] = 32'h0000ABCD;
    nonce_valid = 6'b001000;
    step();
    nonce_valid = '0;
    step(150);
    exp_q.delete();
    exp_q.push_back(32'h0000ABCD);
`ifndef GOLDEN_NONCE_DEDUP_EN
    exp_q.push_back(32'h0000ABCD);
`endif
    check_seq("t6_model_sent", m_sent, exp_q);
    check_seq("t6_dut_sent", d_sent, exp_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
